// File: rtl/mmio_bridge_pkg.sv
// Shared address map and access-target decode for the dmem MMIO bridge.
package mmio_bridge_pkg;

    // Peripheral word addresses
    localparam logic [31:0] BTN_POP     = 32'h0000_1000;
    localparam logic [31:0] BTN_STAT    = 32'h0000_1001;
    localparam logic [31:0] TICK_PERIOD = 32'h0000_1002;
    localparam logic [31:0] TICK_FLAG   = 32'h0000_1003;
    localparam logic [31:0] SCORE       = 32'h0000_1004;

    typedef enum logic [2:0] {
        T_RAM,
        T_BTN_POP,
        T_BTN_STAT,
        T_TICK_PERIOD,
        T_TICK_FLAG,
        T_SCORE,
        T_NONE
    } target_e;

    // RAM covers word addresses below 2**ram_aw; everything else is matched exactly.
    function automatic target_e decode(input logic [31:0] addr, input int unsigned ram_aw);
        target_e t;
        t = T_NONE;
        if ((addr >> ram_aw) == 32'd0) begin
            t = T_RAM;
        end else begin
            case (addr)
                BTN_POP:     t = T_BTN_POP;
                BTN_STAT:    t = T_BTN_STAT;
                TICK_PERIOD: t = T_TICK_PERIOD;
                TICK_FLAG:   t = T_TICK_FLAG;
                SCORE:       t = T_SCORE;
                default:     t = T_NONE;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge (the freed slot is written through).
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array, written on every accepted push
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// dmem-side bridge: splits processor accesses between the data RAM and the
// Tetris peripherals (button FIFO, tick timer, score) and registers q_dmem.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned RAM_AW       = 12,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] TICK_DEFAULT = 32'd500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    input  logic              isLWSW,
    output logic [31:0]       q_dmem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    input  logic [3:0]        buttons,
    output logic [31:0]       score,
    output logic              tick_pending
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    target_e     tgt;
    logic        rd;
    logic        wr;
    logic [31:0] rd_val;
    logic [31:0] q_reg;
    logic        sel_periph;

    logic [3:0]  btn_s1;
    logic [3:0]  btn_s2;
    logic [3:0]  btn_s3;
    logic [3:0]  pend;
    logic [3:0]  pend_clr;
    logic [3:0]  pend_idx;
    logic        ovf;

    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          drop;

    logic [31:0] period;
    logic [31:0] counter;
    logic        tick;
    logic        period_wr;

    assign tgt = decode(address_dmem, RAM_AW);
    assign rd  = isLWSW & ~wren;
    assign wr  = isLWSW & wren;

    assign ram_addr = address_dmem[RAM_AW-1:0];
    assign ram_data = data;
    assign ram_wren = wr & (tgt == T_RAM);

    assign q_dmem = sel_periph ? q_reg : ram_q;

    // Lowest-index pending button wins the single push slot this clock
    always_comb begin
        pend_idx = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (pend[i-1]) pend_idx = 4'(i - 1);
        end
        pend_clr = 4'b0001 << pend_idx;
    end

    assign fifo_push = |pend;
    assign fifo_pop  = rd & (tgt == T_BTN_POP);
    assign drop      = fifo_push & fifo_full & ~(fifo_pop & ~fifo_empty);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({1'b1, 27'b0, pend_idx}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign period_wr = wr & (tgt == T_TICK_PERIOD);
    assign tick      = (period != '0) && (counter == period - 32'd1);

    // Peripheral read data for the addressed target
    always_comb begin
        rd_val = '0;
        case (tgt)
            T_BTN_POP:     rd_val = fifo_empty ? '0 : fifo_head;
            T_BTN_STAT:    rd_val = {ovf, 31'(fifo_count)};
            T_TICK_PERIOD: rd_val = period;
            T_TICK_FLAG:   rd_val = {31'b0, tick_pending};
            T_SCORE:       rd_val = score;
            default:       rd_val = '0;
        endcase
    end

    // Read-return registers: select and peripheral data, one clock latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg      <= '0;
            sel_periph <= 1'b0;
        end else begin
            q_reg      <= rd ? rd_val : '0;
            sel_periph <= (tgt != T_RAM);
        end
    end

    // Button synchronizers, edge capture into the pending mask, overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_s3 <= '0;
            pend   <= '0;
            ovf    <= 1'b0;
        end else begin
            btn_s1 <= buttons;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            pend   <= (pend & ~pend_clr) | (btn_s2 & ~btn_s3);
            ovf    <= (ovf & ~(rd & (tgt == T_BTN_STAT))) | drop;
        end
    end

    // Tick timer; a tick on the clearing edge keeps the flag set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period       <= TICK_DEFAULT;
            counter      <= '0;
            tick_pending <= 1'b0;
        end else begin
            if (period_wr) begin
                period  <= data;
                counter <= '0;
            end else if (tick) begin
                counter <= '0;
            end else if (period != '0) begin
                counter <= counter + 32'd1;
            end
            tick_pending <= (tick_pending & ~(rd & (tgt == T_TICK_FLAG))) | (tick & ~period_wr);
        end
    end

    // Score register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) score <= '0;
        else if (wr && tgt == T_SCORE) score <= data;
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: vector table, directed corner
// sequences, then randomized accesses against a behavioural model.
module tb_mmio_bridge;

    localparam logic [31:0] A_POP    = 32'h1000;
    localparam logic [31:0] A_STAT   = 32'h1001;
    localparam logic [31:0] A_PERIOD = 32'h1002;
    localparam logic [31:0] A_FLAG   = 32'h1003;
    localparam logic [31:0] A_SCORE  = 32'h1004;
    localparam logic [31:0] DEF_PER  = 32'd500000;
    localparam int NRAND = 3000;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic        isLWSW;
    logic [31:0] q_dmem;
    logic [11:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [3:0]  buttons;
    logic [31:0] score;
    logic        tick_pending;

    int total = 0;
    int bad   = 0;

    mmio_bridge #(
        .RAM_AW       (12),
        .FIFO_DEPTH   (4),
        .TICK_DEFAULT (DEF_PER)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .isLWSW       (isLWSW),
        .q_dmem       (q_dmem),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .buttons      (buttons),
        .score        (score),
        .tick_pending (tick_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External data RAM with registered read
    logic [31:0] mem [4096];
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                          output logic [31:0] q);
        address_dmem = a;
        data         = d;
        wren         = we;
        isLWSW       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        q      = q_dmem;
        isLWSW = 1'b0;
        wren   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        access(a, 32'h0, 1'b0, q);
        check(name, q, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        access(a, d, 1'b1, q);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    // Behavioural reference state for the random phase
    logic [31:0] ref_mem [4096];
    logic [31:0] fq [$];
    logic [3:0]  hist [NRAND + 8];
    logic [3:0]  m_pend;
    logic        m_ovf;
    logic        m_flag;
    logic [31:0] m_score;
    logic [31:0] m_period;
    int unsigned t;
    int unsigned t_load;

    initial begin
        logic [31:0] q;
        logic [31:0] a, d, exp_q;
        logic        v, we, rdv, wrv, pop, do_push, nxt_ovf, tk;
        logic [3:0]  btn;
        int          k, lo, pidx, sz;

        reset = 1'b1;
        address_dmem = '0;
        data = '0;
        wren = 1'b0;
        isLWSW = 1'b0;
        buttons = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("reset_q", q_dmem, 32'h0);
        check("reset_score", score, 32'h0);
        check("reset_tick", {31'h0, tick_pending}, 32'h0);

        // ---- RAM store/load with write-strobe timing
        address_dmem = 32'd5;
        data = 32'h0000_00AB;
        wren = 1'b1;
        isLWSW = 1'b1;
        #1;
        check("ram_wren_on", {31'h0, ram_wren}, 32'h1);
        check("ram_addr", {20'h0, ram_addr}, 32'd5);
        check("ram_data", ram_data, 32'hAB);
        @(posedge clock);
        @(negedge clock);
        isLWSW = 1'b0;
        wren = 1'b0;
        #1;
        check("ram_wren_off", {31'h0, ram_wren}, 32'h0);
        @(negedge clock);
        rd_chk("ram_lw5", 32'd5, 32'hAB);

        // ---- vector table
        vecs[0]  = '{"def_period", A_PERIOD, 32'h0, 1'b0, DEF_PER};
        vecs[1]  = '{"score0", A_SCORE, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{"stat0", A_STAT, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{"", A_SCORE, 32'h0000_1234, 1'b1, 32'h0};
        vecs[4]  = '{"score_rb", A_SCORE, 32'h0, 1'b0, 32'h0000_1234};
        vecs[5]  = '{"", 32'h0000_0FFF, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[6]  = '{"ram_top", 32'h0000_0FFF, 32'h0, 1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{"unmap_rd", 32'h0000_2000, 32'h0, 1'b0, 32'h0};
        vecs[8]  = '{"", 32'h0000_2000, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[9]  = '{"unmap_rd2", 32'h0000_2000, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{"", 32'h0001_1004, 32'h5555_5555, 1'b1, 32'h0};
        vecs[11] = '{"alias_score", A_SCORE, 32'h0, 1'b0, 32'h0000_1234};
        vecs[12] = '{"pop_empty", A_POP, 32'h0, 1'b0, 32'h0};
        vecs[13] = '{"flag0", A_FLAG, 32'h0, 1'b0, 32'h0};
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            else rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        check("score_port", score, 32'h0000_1234);

        // ---- button ordering
        buttons = 4'b0100;
        idle(3);
        buttons = 4'b0000;
        idle(2);
        buttons = 4'b1001;
        idle(3);
        buttons = 4'b0000;
        idle(4);
        rd_chk("btn_pop1", A_POP, 32'h8000_0002);
        rd_chk("btn_pop2", A_POP, 32'h8000_0000);
        rd_chk("btn_pop3", A_POP, 32'h8000_0003);
        rd_chk("btn_pop4", A_POP, 32'h0000_0000);

        // ---- FIFO overflow
        repeat (5) begin
            buttons[1] = 1'b1;
            idle(2);
            buttons[1] = 1'b0;
            idle(2);
        end
        idle(4);
        rd_chk("ovf_stat1", A_STAT, 32'h8000_0004);
        rd_chk("ovf_stat2", A_STAT, 32'h0000_0004);

        // ---- push and pop on the same edge while full
        buttons[1] = 1'b1;
        idle(3);
        rd_chk("full_pop", A_POP, 32'h8000_0001);
        rd_chk("full_stat", A_STAT, 32'h0000_0004);
        buttons[1] = 1'b0;
        rd_chk("drain1", A_POP, 32'h8000_0001);
        rd_chk("drain2", A_POP, 32'h8000_0001);

        // ---- timer
        wr(A_PERIOD, 32'd10);
        idle(9);
        check("tick_e9", {31'h0, tick_pending}, 32'h0);
        idle(1);
        check("tick_e10", {31'h0, tick_pending}, 32'h1);
        rd_chk("flag_rd1", A_FLAG, 32'h1);
        rd_chk("flag_rd0", A_FLAG, 32'h0);
        idle(17);
        rd_chk("flag_on_tick", A_FLAG, 32'h1);
        check("flag_kept", {31'h0, tick_pending}, 32'h1);
        rd_chk("flag_rd_again", A_FLAG, 32'h1);
        check("flag_cleared", {31'h0, tick_pending}, 32'h0);
        rd_chk("period_rb", A_PERIOD, 32'd10);
        wr(A_PERIOD, 32'd0);
        idle(100);
        check("period0_notick", {31'h0, tick_pending}, 32'h0);
        rd_chk("period0_rb", A_PERIOD, 32'd0);

        // ---- reset mid-operation (FIFO holds 2)
        wr(A_SCORE, 32'd7);
        check("score7", score, 32'd7);
        wr(A_PERIOD, 32'd20);
        idle(5);
        #2 reset = 1'b1;
        #1;
        check("rst_async_score", score, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        rd_chk("rst_stat", A_STAT, 32'h0);
        rd_chk("rst_period", A_PERIOD, DEF_PER);
        rd_chk("rst_score", A_SCORE, 32'h0);
        rd_chk("rst_unmap", 32'h0000_2000, 32'h0);
        rd_chk("rst_pop", A_POP, 32'h0);

        // ---- randomized phase against the reference model
        do_reset();
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < NRAND + 8; i++) hist[i] = '0;
        fq.delete();
        m_pend = '0;
        m_ovf = 1'b0;
        m_flag = 1'b0;
        m_score = '0;
        m_period = DEF_PER;
        t = 0;
        t_load = 0;
        btn = '0;

        for (int n = 0; n < NRAND; n++) begin
            k = $urandom_range(0, 11);
            v = 1'b1;
            we = 1'b0;
            d = $urandom;
            a = 32'h0;
            case (k)
                0: begin a = 32'h800 + $urandom_range(0, 15); we = 1'b1; end
                1: a = 32'h800 + $urandom_range(0, 15);
                2: a = A_POP;
                3: a = A_STAT;
                4: begin
                    a = A_PERIOD;
                    we = 1'b1;
                    d = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
                end
                5: a = A_PERIOD;
                6: a = A_FLAG;
                7: begin a = A_SCORE; we = 1'b1; end
                8: a = A_SCORE;
                9: begin
                    lo = $urandom_range(0, 7);
                    if (lo == 7) a = 32'h1005 + $urandom_range(0, 255);
                    else a = (($urandom | 32'h0001_0000) & 32'hFFFF_0000)
                             | ((lo < 5) ? 32'h1000 + 32'(lo) : 32'h800 + 32'(lo));
                    we = 1'($urandom_range(0, 1));
                end
                10: begin
                    lo = $urandom_range(0, 2);
                    a = (lo == 2) ? A_FLAG : A_POP + 32'(lo);
                    we = 1'b1;
                end
                default: begin
                    a = 32'h1000 + $urandom_range(0, 4);
                    v = 1'b0;
                    we = 1'($urandom_range(0, 1));
                end
            endcase
            if ($urandom_range(0, 5) == 0) btn = btn ^ (4'b0001 << $urandom_range(0, 3));

            address_dmem = a;
            data = d;
            wren = we;
            isLWSW = v;
            buttons = btn;
            rdv = v && !we;
            wrv = v && we;
            #1;
            check("rnd_ram_wren", {31'h0, ram_wren}, {31'h0, wrv && (a < 32'd4096)});

            t = t + 1;
            hist[t + 3] = btn;
            sz = fq.size();

            exp_q = 32'h0;
            if (rdv) begin
                if (a < 32'd4096) exp_q = ref_mem[a[11:0]];
                else if (a == A_POP) exp_q = (sz != 0) ? fq[0] : 32'h0;
                else if (a == A_STAT) exp_q = {m_ovf, 28'h0, 3'(sz)};
                else if (a == A_PERIOD) exp_q = m_period;
                else if (a == A_FLAG) exp_q = {31'h0, m_flag};
                else if (a == A_SCORE) exp_q = m_score;
            end

            pop = rdv && (a == A_POP) && (sz != 0);
            nxt_ovf = m_ovf && !(rdv && a == A_STAT);
            do_push = 1'b0;
            pidx = 0;
            if (m_pend != 4'b0) begin
                for (int b = 3; b >= 0; b--) if (m_pend[b]) pidx = b;
                m_pend[pidx] = 1'b0;
                if (sz - (pop ? 1 : 0) < 4) do_push = 1'b1;
                else nxt_ovf = 1'b1;
            end
            if (pop) void'(fq.pop_front());
            if (do_push) fq.push_back({1'b1, 27'h0, 4'(pidx)});
            m_pend = m_pend | (hist[t + 1] & ~hist[t]);
            m_ovf = nxt_ovf;
            if (wrv && a < 32'd4096) ref_mem[a[11:0]] = d;
            if (wrv && a == A_SCORE) m_score = d;
            tk = 1'b0;
            if (wrv && a == A_PERIOD) begin
                m_period = d;
                t_load = t;
            end else if (m_period != 32'd0 && ((t - t_load) % m_period) == 0) begin
                tk = 1'b1;
            end
            m_flag = (m_flag && !(rdv && a == A_FLAG)) || tk;

            @(posedge clock);
            @(negedge clock);
            if (rdv) check("rnd_q", q_dmem, exp_q);
            check("rnd_score", score, m_score);
            check("rnd_tick", {31'h0, tick_pending}, {31'h0, m_flag});
        end
        isLWSW = 1'b0;
        wren = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
